// File: rtl/usb_pkg.sv
// Shared USB receive definitions.
// Holds the SYNC byte and PID byte constants, the decoded packet-type enum,
// the receive FSM state enum, payload sizing constants and small helpers
// used by the receive packet controller.
package usb_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam int MAX_PAYLOAD = 64;
  localparam int CRC_BYTES   = 2;

  // Largest legal post-PID byte count of a data packet (payload + CRC16).
  localparam logic [6:0] BODY_MAX = 7'(MAX_PAYLOAD + CRC_BYTES);
  // Buffer fill level at which no further byte may be pushed.
  localparam logic [6:0] BUF_FULL = 7'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_OUT   = 3'd1,
    PKT_IN    = 3'd2,
    PKT_DATA0 = 3'd3,
    PKT_DATA1 = 3'd4,
    PKT_ACK   = 3'd5,
    PKT_NAK   = 3'd6,
    PKT_STALL = 3'd7
  } rx_pkt_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PID  = 3'd1,
    ST_BODY = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } rx_state_e;

  // Maps a PID byte to its packet type; PKT_NONE for a byte that fails the
  // nibble-complement check or is not one of the recognised PIDs.
  function automatic rx_pkt_e decode_pid(input logic [7:0] pid);
    rx_pkt_e t;
    t = PKT_NONE;
    if (pid[7:4] == ~pid[3:0]) begin
      case (pid)
        PID_OUT:   t = PKT_OUT;
        PID_IN:    t = PKT_IN;
        PID_DATA0: t = PKT_DATA0;
        PID_DATA1: t = PKT_DATA1;
        PID_ACK:   t = PKT_ACK;
        PID_NAK:   t = PKT_NAK;
        PID_STALL: t = PKT_STALL;
        default:   t = PKT_NONE;
      endcase
    end
    return t;
  endfunction

  // 7-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7F) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/rx_packet_ctrl_if.sv
// Receive-side bus between the byte decoder / data buffer and the
// receive packet controller.
//   byte_valid, rx_byte, eop, buffer_occupancy : decoder/buffer -> controller
//   rx_packet, rx_data_ready, rx_transfer_active, rx_error,
//   store_rx_packet_data, rx_packet_data     : controller -> system/buffer
// master: the side that drives the received bytes (decoder, or a bench).
// slave : the receive packet controller.
interface rx_packet_ctrl_if;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       eop;
  logic [6:0] buffer_occupancy;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;

  modport master (
    output byte_valid, rx_byte, eop, buffer_occupancy,
    input  rx_packet, rx_data_ready, rx_transfer_active, rx_error,
           store_rx_packet_data, rx_packet_data
  );

  modport slave (
    input  byte_valid, rx_byte, eop, buffer_occupancy,
    output rx_packet, rx_data_ready, rx_transfer_active, rx_error,
           store_rx_packet_data, rx_packet_data
  );
endinterface

// File: rtl/rx_byte_delay.sv
// Two-byte holding pipeline for data packets. Every accepted data byte is
// shifted in; o_oldest is the byte that leaves the pipe on the next shift,
// so the last two bytes of a packet (the CRC16) are still held at eop and
// never reach the buffer.
// Ports: clk, n_rst (async active-low), i_clear (start of packet),
//        i_shift, i_byte (byte to shift in), o_oldest (oldest held byte).
module rx_byte_delay (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_clear,
  input  logic       i_shift,
  input  logic [7:0] i_byte,
  output logic [7:0] o_oldest
);

  logic [7:0] r_newest;
  logic [7:0] r_oldest;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_newest <= 8'h00;
      r_oldest <= 8'h00;
    end else if (i_clear) begin
      r_newest <= 8'h00;
      r_oldest <= 8'h00;
    end else if (i_shift) begin
      r_oldest <= r_newest;
      r_newest <= i_byte;
    end
  end

  assign o_oldest = r_oldest;

endmodule

// File: rtl/rx_packet_ctrl.sv
// Receive packet controller: parses SYNC, PID and body bytes, checks the
// body length per packet type, forwards data payload (minus CRC16) to the
// data buffer and reports the completed packet type or an error.
// Ports: clk, n_rst (async active-low), bus (rx_packet_ctrl_if.slave).
// All outputs are registered.
module rx_packet_ctrl
  import usb_pkg::*;
(
  input logic            clk,
  input logic            n_rst,
  rx_packet_ctrl_if.slave bus
);

  rx_state_e  r_state,      w_state_next;
  logic [6:0] r_cnt,        w_cnt_next;
  rx_pkt_e    r_pkt_type,   w_pkt_type_next;
  logic       r_err_eop,    w_err_eop_next;
  rx_pkt_e    r_packet,     w_packet_next;
  logic       r_data_ready, w_data_ready_next;
  logic       r_active,     w_active_next;
  logic       r_error,      w_error_next;
  logic       r_store,      w_store_next;
  logic [7:0] r_data;

  logic       w_shift;
  logic       w_clear;
  logic [7:0] w_oldest;
  logic       w_byte;
  logic       w_is_data;
  logic       w_is_token;
  logic       w_need_push;
  rx_pkt_e    w_pid_type;

  // A byte arriving together with eop is dropped; eop wins.
  assign w_byte      = bus.byte_valid & ~bus.eop;
  assign w_pid_type  = decode_pid(bus.rx_byte);
  assign w_is_data   = (r_pkt_type == PKT_DATA0) || (r_pkt_type == PKT_DATA1);
  assign w_is_token  = (r_pkt_type == PKT_OUT) || (r_pkt_type == PKT_IN);
  // Two bytes already held: the incoming byte forces the oldest one out.
  assign w_need_push = (r_cnt >= 7'd2);

  rx_byte_delay u_delay (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (w_clear),
    .i_shift  (w_shift),
    .i_byte   (bus.rx_byte),
    .o_oldest (w_oldest)
  );

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_pkt_type_next   = r_pkt_type;
    w_err_eop_next    = 1'b0;
    w_packet_next     = r_packet;
    w_error_next      = r_error;
    w_data_ready_next = 1'b0;
    w_store_next      = 1'b0;
    w_shift           = 1'b0;
    w_clear           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_byte) begin
          if (bus.rx_byte == SYNC_BYTE) begin
            w_state_next = ST_PID;
            w_cnt_next   = 7'd0;
            w_error_next = 1'b0;
            w_clear      = 1'b1;
          end else begin
            w_state_next  = ST_ERR;
            w_error_next  = 1'b1;
            w_packet_next = PKT_NONE;
          end
        end
      end

      ST_PID: begin
        if (bus.eop) begin
          // eop already consumed: ERR must not wait for another one.
          w_state_next   = ST_ERR;
          w_err_eop_next = 1'b1;
          w_error_next   = 1'b1;
          w_packet_next  = PKT_NONE;
        end else if (w_byte) begin
          if (w_pid_type != PKT_NONE) begin
            w_state_next    = ST_BODY;
            w_pkt_type_next = w_pid_type;
            w_cnt_next      = 7'd0;
          end else begin
            w_state_next  = ST_ERR;
            w_error_next  = 1'b1;
            w_packet_next = PKT_NONE;
          end
        end
      end

      ST_BODY: begin
        if (bus.eop) begin
          if ((w_is_token && r_cnt == 7'd2) ||
              (w_is_data && r_cnt >= 7'd2) ||
              (!w_is_token && !w_is_data && r_cnt == 7'd0)) begin
            w_state_next      = ST_DONE;
            w_packet_next     = r_pkt_type;
            w_data_ready_next = w_is_data;
          end else begin
            w_state_next   = ST_ERR;
            w_err_eop_next = 1'b1;
            w_error_next   = 1'b1;
            w_packet_next  = PKT_NONE;
          end
        end else if (w_byte) begin
          if (w_is_data) begin
            if ((r_cnt >= BODY_MAX) ||
                (w_need_push && bus.buffer_occupancy >= BUF_FULL)) begin
              w_state_next  = ST_ERR;
              w_error_next  = 1'b1;
              w_packet_next = PKT_NONE;
            end else begin
              w_shift      = 1'b1;
              w_store_next = w_need_push;
              w_cnt_next   = sat_inc7(r_cnt);
            end
          end else begin
            w_cnt_next = sat_inc7(r_cnt);
          end
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
      end

      ST_ERR: begin
        if (bus.eop || r_err_eop) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_active_next = (w_state_next == ST_PID) || (w_state_next == ST_BODY) ||
                    (w_state_next == ST_ERR);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 7'd0;
      r_pkt_type   <= PKT_NONE;
      r_err_eop    <= 1'b0;
      r_packet     <= PKT_NONE;
      r_data_ready <= 1'b0;
      r_active     <= 1'b0;
      r_error      <= 1'b0;
      r_store      <= 1'b0;
      r_data       <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_pkt_type   <= w_pkt_type_next;
      r_err_eop    <= w_err_eop_next;
      r_packet     <= w_packet_next;
      r_data_ready <= w_data_ready_next;
      r_active     <= w_active_next;
      r_error      <= w_error_next;
      r_store      <= w_store_next;
      if (w_store_next) begin
        r_data <= w_oldest;
      end
    end
  end

  assign bus.rx_packet            = r_packet;
  assign bus.rx_data_ready        = r_data_ready;
  assign bus.rx_transfer_active   = r_active;
  assign bus.rx_error             = r_error;
  assign bus.store_rx_packet_data = r_store;
  assign bus.rx_packet_data       = r_data;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Scoreboard bench for rx_packet_ctrl. The stimulus side builds each packet
// as a byte list, computes the expected pushes and end-of-packet result from
// the packet rules, and queues them; a monitor pops and compares whenever
// the DUT pushes a byte or ends a transfer.
module tb_rx_packet_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  rx_packet_ctrl_if bus ();

  rx_packet_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] pkt;
    logic       err;
    logic       rdy;
  } comp_t;

  comp_t      exp_comp[$];
  logic [7:0] exp_push[$];
  logic [7:0] q_pkt[$];
  int checks = 0;
  int errors = 0;
  int exp_ready = 0;
  int got_ready = 0;
  int pkt_no = 0;
  logic prev_active = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pid_type(input logic [7:0] b);
    case (b)
      8'hE1:   return 1;
      8'h69:   return 2;
      8'hC3:   return 3;
      8'h4B:   return 4;
      8'hD2:   return 5;
      8'h5A:   return 6;
      8'h1E:   return 7;
      default: return 0;
    endcase
  endfunction

  // Expected outcome of q_pkt (bytes before eop) with fixed buffer occupancy.
  task automatic model(input int occ);
    comp_t c;
    int t, len, want;
    c.pkt = 3'd0; c.err = 1'b1; c.rdy = 1'b0;
    if (q_pkt.size() >= 2 && q_pkt[0] == 8'h80) begin
      t   = pid_type(q_pkt[1]);
      len = q_pkt.size() - 2;
      if ((t == 1 || t == 2) && len == 2) begin
        c.pkt = 3'(t); c.err = 1'b0;
      end else if (t >= 5 && len == 0) begin
        c.pkt = 3'(t); c.err = 1'b0;
      end else if ((t == 3 || t == 4) && len >= 2) begin
        want = ((len > 66) ? 66 : len) - 2;
        if (want > 0 && occ >= 64) begin
          // first push hits a full buffer: nothing stored, packet fails
        end else begin
          for (int i = 0; i < want; i++) exp_push.push_back(q_pkt[2+i]);
          if (len <= 66) begin
            c.pkt = 3'(t); c.err = 1'b0; c.rdy = 1'b1;
            exp_ready++;
          end
        end
      end
    end
    exp_comp.push_back(c);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.rx_byte    = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic drive_eop(input bit with_byte);
    @(negedge clk);
    bus.eop = 1'b1;
    if (with_byte) begin
      bus.byte_valid = 1'b1;
      bus.rx_byte    = 8'($urandom);
    end
    @(negedge clk);
    bus.eop        = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_packet(input int occ, input bit collide);
    bus.buffer_occupancy = 7'(occ);
    model(occ);
    $display("pkt %0d bytes %0d occ %0d collide %0d expect pkt=%0d err=%0d",
             pkt_no, q_pkt.size(), occ, collide, exp_comp[$].pkt, exp_comp[$].err);
    pkt_no++;
    foreach (q_pkt[i]) drive_byte(q_pkt[i]);
    drive_eop(collide);
  endtask

  task automatic build_random(output int occ, output bit collide);
    int kind, len;
    logic [7:0] b;
    q_pkt.delete();
    kind = $urandom_range(0, 9);
    len  = 0;
    if (kind <= 3) begin
      q_pkt.push_back(8'h80);
      q_pkt.push_back(($urandom_range(0, 1) == 0) ? 8'hC3 : 8'h4B);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 8);
    end else if (kind <= 5) begin
      q_pkt.push_back(8'h80);
      q_pkt.push_back(($urandom_range(0, 1) == 0) ? 8'hE1 : 8'h69);
      len = $urandom_range(1, 3);
    end else if (kind == 6) begin
      q_pkt.push_back(8'h80);
      case ($urandom_range(0, 2))
        0:       q_pkt.push_back(8'hD2);
        1:       q_pkt.push_back(8'h5A);
        default: q_pkt.push_back(8'h1E);
      endcase
      len = ($urandom_range(0, 3) == 0) ? 1 : 0;
    end else if (kind == 7) begin
      q_pkt.push_back(8'h80);
      q_pkt.push_back(8'($urandom));
      len = $urandom_range(0, 3);
    end else if (kind == 8) begin
      b = 8'($urandom);
      if (b == 8'h80) b = 8'h81;
      q_pkt.push_back(b);
      len = $urandom_range(0, 2);
    end else begin
      q_pkt.push_back(8'h80);
    end
    for (int i = 0; i < len; i++) q_pkt.push_back(8'($urandom));
    occ     = ($urandom_range(0, 5) == 0) ? 64 : $urandom_range(0, 63);
    collide = ($urandom_range(0, 3) == 0);
  endtask

  // Monitor: pushes and end-of-transfer results against the scoreboard.
  initial begin
    comp_t c;
    forever begin
      @(negedge clk);
      if (bus.store_rx_packet_data) begin
        if (exp_push.size() == 0) chk("push_unexpected", exp_push.size(), 1);
        else chk("push_data", bus.rx_packet_data, exp_push.pop_front());
      end
      if (bus.rx_data_ready) got_ready++;
      if (prev_active && !bus.rx_transfer_active) begin
        if (exp_comp.size() == 0) begin
          chk("end_unexpected", exp_comp.size(), 1);
        end else begin
          c = exp_comp.pop_front();
          chk("end_rx_packet", bus.rx_packet, c.pkt);
          chk("end_rx_error", bus.rx_error, c.err);
          chk("end_rx_data_ready", bus.rx_data_ready, c.rdy);
          if (c.rdy == 1'b0 || c.err == 1'b1)
            chk("end_no_push_left", exp_push.size(), 0);
        end
      end
      prev_active = bus.rx_transfer_active;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int occ;
    bit collide;
    bus.byte_valid = 1'b0;
    bus.rx_byte = 8'h00;
    bus.eop = 1'b0;
    bus.buffer_occupancy = 7'd0;
    repeat (3) @(negedge clk);
    chk("rst_rx_packet", bus.rx_packet, 0);
    chk("rst_data_ready", bus.rx_data_ready, 0);
    chk("rst_active", bus.rx_transfer_active, 0);
    chk("rst_error", bus.rx_error, 0);
    chk("rst_store", bus.store_rx_packet_data, 0);
    chk("rst_data", bus.rx_packet_data, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    q_pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hA1, 8'hB2};
    run_packet(0, 0);
    q_pkt = '{8'h80, 8'h69, 8'h81, 8'h58};
    run_packet(10, 0);
    q_pkt = '{8'h80, 8'hD2};
    run_packet(0, 0);
    q_pkt = '{8'h80, 8'hD2, 8'h00};
    run_packet(0, 0);

    // corrupted PID: transfer stays active until eop
    q_pkt = '{8'h80, 8'hC4, 8'h00};
    bus.buffer_occupancy = 7'd0;
    model(0);
    $display("pkt %0d corrupted PID C4", pkt_no);
    pkt_no++;
    drive_byte(8'h80);
    drive_byte(8'hC4);
    repeat (3) begin
      @(negedge clk);
      chk("err_active_held", bus.rx_transfer_active, 1);
    end
    drive_byte(8'h00);
    drive_eop(0);
    q_pkt = '{8'h80, 8'h69, 8'h81, 8'h58};
    run_packet(0, 0);

    q_pkt = '{8'h80, 8'hC3, 8'h01, 8'h02, 8'h03};
    run_packet(64, 0);

    // reset mid-packet after two payload bytes
    bus.buffer_occupancy = 7'd0;
    exp_comp.push_back('0);
    $display("pkt %0d reset after two payload bytes", pkt_no);
    pkt_no++;
    drive_byte(8'h80);
    drive_byte(8'hC3);
    drive_byte(8'h11);
    drive_byte(8'h22);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_rx_packet", bus.rx_packet, 0);
    chk("mid_rst_data_ready", bus.rx_data_ready, 0);
    chk("mid_rst_active", bus.rx_transfer_active, 0);
    chk("mid_rst_error", bus.rx_error, 0);
    chk("mid_rst_store", bus.store_rx_packet_data, 0);
    chk("mid_rst_data", bus.rx_packet_data, 0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    repeat (2) @(negedge clk);
    q_pkt = '{8'h80, 8'h4B, 8'hAA, 8'hC0, 8'hDE};
    run_packet(0, 0);

    // boundary: exactly 64 payload bytes, then one too many
    q_pkt = '{8'h80, 8'hC3};
    for (int i = 0; i < 66; i++) q_pkt.push_back(8'($urandom));
    run_packet(0, 0);
    q_pkt = '{8'h80, 8'h4B};
    for (int i = 0; i < 67; i++) q_pkt.push_back(8'($urandom));
    run_packet(0, 0);

    for (int n = 0; n < 200; n++) begin
      build_random(occ, collide);
      run_packet(occ, collide);
    end

    for (int i = 0; i < 50 && (exp_push.size() != 0 || exp_comp.size() != 0); i++)
      @(negedge clk);
    chk("push_queue_drained", exp_push.size(), 0);
    chk("end_queue_drained", exp_comp.size(), 0);
    chk("data_ready_count", got_ready, exp_ready);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_packet_ctrl.md
RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 Clock and reset: clk; reset n_rst, asynchronous, active-low.
REQ-002 clk  input  1  system clock.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 byte_valid  input  1  one-cycle strobe; rx_byte holds a decoded received byte.
REQ-005 rx_byte  input  8  received byte, LSB = first bit on the wire.
REQ-006 eop  input  1  one-cycle strobe marking end of packet on the bus.
REQ-007 buffer_occupancy  input  7  data buffer fill level, 0..64.
REQ-008 rx_packet  output  3  last completed packet type: 0 NONE, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL.
REQ-009 rx_data_ready  output  1  one-cycle pulse when a good DATA0/DATA1 packet completes.
REQ-010 rx_transfer_active  output  1  high while a packet is being received.
REQ-011 rx_error  output  1  level; the last packet was malformed.
REQ-012 store_rx_packet_data  output  1  one-cycle push strobe to the data buffer.
REQ-013 rx_packet_data  output  8  payload byte valid with store_rx_packet_data.

Function
REQ-014 The FSM SHALL have states IDLE, PID, BODY, DONE and ERR, and all outputs SHALL be registered.
- IDLE: byte_valid with rx_byte==8'h80 (SYNC) -> PID.
- IDLE: any other byte_valid -> ERR.
- IDLE: eop is ignored.
REQ-015 PID state, byte_valid:
- A valid PID requires rx_byte[7:4] == ~rx_byte[3:0].
- PID values: OUT 8'hE1, IN 8'h69, DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
- A valid, recognised PID is latched and the FSM goes to BODY.
- Any other byte -> ERR.
REQ-016 PID state, eop -> ERR.
REQ-017 BODY SHALL count post-PID bytes with a 7-bit saturating counter.
REQ-018 BODY, eop: byte-count check.
- OUT/IN: exactly 2 bytes.
- Handshake (ACK/NAK/STALL): exactly 0 bytes.
- DATA0/DATA1: at least 2 bytes.
- Pass -> DONE; fail -> ERR.
REQ-019 Data packets SHALL pass through a 2-byte holding pipeline.
- Each byte_valid beyond the 2nd shifts the oldest held byte out onto rx_packet_data with store_rx_packet_data=1, one cycle after the strobe.
- The final 2 bytes (CRC16) are never pushed.
REQ-020 Token and handshake bytes SHALL never be pushed.
REQ-021 Overflow: a push required while buffer_occupancy==64 -> no push, go to ERR.
REQ-022 Payload limit: a data packet with more than 66 post-PID bytes -> ERR at the 67th byte.
REQ-023 DONE lasts one cycle, then IDLE.
- rx_packet is updated with the decoded type.
- rx_data_ready pulses for DATA0/DATA1 only.
REQ-024 ERR: rx_error=1, rx_packet=NONE, FSM waits for eop, then IDLE.
REQ-025 rx_error SHALL clear when the next SYNC is accepted.
REQ-026 rx_packet SHALL hold its value until the next DONE or ERR.
REQ-027 rx_transfer_active SHALL be 1 in PID, BODY and ERR, and 0 in IDLE and DONE.
REQ-028 byte_valid and eop in the same cycle: the byte is discarded and eop is processed.
REQ-029 Counter arithmetic SHALL saturate; there is no wrap-around.

Reset
REQ-030 On n_rst low: state IDLE, counter 0, holding registers 0.
REQ-031 Output reset values: rx_packet=0, rx_data_ready=0, rx_transfer_active=0, rx_error=0, store_rx_packet_data=0, rx_packet_data=8'h00.
REQ-032 Reset asserted mid-packet SHALL abort with no further pushes; the next packet starts from IDLE.

Structure
REQ-033 A shared package (usb_pkg) SHALL hold:
- PID byte constants and the SYNC constant.
- The rx_packet type enum.
- Max payload (64).
REQ-034 The 2-byte holding pipeline SHALL be a sub-module named rx_byte_delay.

Verification
REQ-035 SYNC, C3, 11, 22, 33, A1, B2, eop -> pushes 11, 22, 33; rx_packet=3; rx_data_ready pulses once; rx_error=0.
REQ-036 SYNC, 69, 81, 58, eop -> rx_packet=2; no push; no rx_data_ready.
REQ-037 SYNC, D2, eop -> rx_packet=5; SYNC, D2, 00, eop -> rx_error=1, rx_packet=0.
REQ-038 SYNC, C3, 00 with PID nibble corruption (byte C4) -> ERR; rx_transfer_active stays 1 until eop; the next good packet clears rx_error.
REQ-039 buffer_occupancy=64, SYNC, C3, 3 data bytes, eop -> no push; rx_error=1.
REQ-040 n_rst asserted after 2 payload bytes -> all outputs 0; a following SYNC, 4B, AA, C0, DE, eop -> push AA only; rx_packet=4.
